// File: rtl/immediate_generate_unit_pkg.sv
// immediate_generate_unit_pkg
// Purpose: IMM_SEL encodings that the control unit and the immediate generator share.
// Ports:   none (package).
// Config:  the IMMGEN_ILLEGAL_FLAG_EN macro does not affect this file.

package immediate_generate_unit_pkg;

   localparam logic [2:0] IMM_U          = 3'b000;
   localparam logic [2:0] IMM_J          = 3'b001;
   localparam logic [2:0] IMM_S          = 3'b010;
   localparam logic [2:0] IMM_B          = 3'b011;
   localparam logic [2:0] IMM_I_SIGNED   = 3'b100;
   localparam logic [2:0] IMM_I_SHIFT    = 3'b101;
   localparam logic [2:0] IMM_I_UNSIGNED = 3'b110;
   localparam logic [2:0] IMM_RSVD       = 3'b111;

   localparam int unsigned InWidth  = 25;
   localparam int unsigned ImmWidth = 32;

endpackage

// File: rtl/immediate_generate_unit_decode.sv
// immediate_decode_comb
// Purpose: combinational immediate mux. It turns instruction bits [31:7] and the
//          immediate-type select into the 32-bit extended immediate.
// Ports:
//   i_in      [24:0] instruction[31:7]; i_in[k] = instr[k+7]
//   i_imm_sel [2:0]  immediate type select
//   o_imm     [31:0] extended immediate (0 for reserved/unknown select)
// Config:  the IMMGEN_ILLEGAL_FLAG_EN macro does not affect this file.

module immediate_decode_comb
   import immediate_generate_unit_pkg::*;
(
   input  logic [InWidth-1:0]  i_in,
   input  logic [2:0]          i_imm_sel,
   output logic [ImmWidth-1:0] o_imm
);

   // instr[31] is the only sign source for every sign-extending type.
   logic w_sign;
   assign w_sign = i_in[24];

   // The indices below are instruction-bit positions minus 7.
   always_comb begin
      o_imm = '0;
      case (i_imm_sel)
         IMM_U:          o_imm = {i_in[24:5], 12'b0};
         IMM_J:          o_imm = {{12{w_sign}}, i_in[12:5], i_in[13], i_in[23:14], 1'b0};
         IMM_S:          o_imm = {{20{w_sign}}, i_in[24:18], i_in[4:0]};
         IMM_B:          o_imm = {{20{w_sign}}, i_in[0], i_in[23:18], i_in[4:1], 1'b0};
         IMM_I_SIGNED:   o_imm = {{20{w_sign}}, i_in[24:13]};
         IMM_I_SHIFT:    o_imm = {27'b0, i_in[17:13]};
         IMM_I_UNSIGNED: o_imm = {20'b0, i_in[24:13]};
         default:        o_imm = '0;
      endcase
   end

endmodule

// File: rtl/immediate_generate_unit.sv
// immediate_generate_unit
// Purpose: decode-stage immediate generator for the RV32IM core. It registers the
//          extended immediate for the execute stage.
// Ports:
//   CLK         in   system clock, rising edge
//   RESET       in   asynchronous active-low reset; clears OUT
//   EN          in   load enable; 0 holds OUT (pipeline stall)
//   IN   [24:0] in   instruction[31:7]
//   IMM_SEL [2:0] in immediate type select
//   OUT  [31:0] out  registered extended immediate
//   ILLEGAL_SEL out  registered flag for a reserved select (only with IMMGEN_ILLEGAL_FLAG_EN)
// Config:  define IMMGEN_ILLEGAL_FLAG_EN to add the ILLEGAL_SEL port and its register.

module immediate_generate_unit
   import immediate_generate_unit_pkg::*;
(
   input  logic                CLK,
   input  logic                RESET,
   input  logic                EN,
   input  logic [InWidth-1:0]  IN,
   input  logic [2:0]          IMM_SEL,
   output logic [ImmWidth-1:0] OUT
`ifdef IMMGEN_ILLEGAL_FLAG_EN
   ,
   output logic                ILLEGAL_SEL
`endif
);

   logic [ImmWidth-1:0] w_imm;
   logic [ImmWidth-1:0] r_out;

   immediate_decode_comb u_decode (
      .i_in      (IN),
      .i_imm_sel (IMM_SEL),
      .o_imm     (w_imm)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_out <= '0;
      end else if (EN) begin
         r_out <= w_imm;
      end
   end

   assign OUT = r_out;

`ifdef IMMGEN_ILLEGAL_FLAG_EN
   logic r_illegal;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_illegal <= 1'b0;
      end else if (EN) begin
         r_illegal <= (IMM_SEL == IMM_RSVD);
      end
   end

   assign ILLEGAL_SEL = r_illegal;
`endif

endmodule

// File: tb/tb_immediate_generate_unit.sv
// tb_immediate_generate_unit
// Purpose: directed self-checking bench for immediate_generate_unit.
// Ports:   none (top-level bench).
// Config:  define IMMGEN_ILLEGAL_FLAG_EN to also check ILLEGAL_SEL.

module tb_immediate_generate_unit;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [24:0] in_bits;
   logic [2:0]  sel;
   logic [31:0] out_imm;
`ifdef IMMGEN_ILLEGAL_FLAG_EN
   logic        illegal;
`endif

   int n_checks = 0;
   int n_errors = 0;

   immediate_generate_unit dut (
      .CLK         (clk),
      .RESET       (rst_n),
      .EN          (en),
      .IN          (in_bits),
      .IMM_SEL     (sel),
      .OUT         (out_imm)
`ifdef IMMGEN_ILLEGAL_FLAG_EN
      ,
      .ILLEGAL_SEL (illegal)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive on the falling edge, take one rising edge, then sample 1 time unit later.
   task automatic apply(input logic [24:0] v_in, input logic [2:0] v_sel, input logic v_en);
      @(negedge clk);
      in_bits = v_in;
      sel     = v_sel;
      en      = v_en;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      en      = 1'b1;
      in_bits = 25'h1FFFFFF;
      sel     = 3'b100;
      #2;
      n_checks++;
      if (out_imm !== 32'h0) begin
         $display("FAIL reset_async: got %h want %h", out_imm, 32'h0);
         n_errors++;
      end
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (out_imm !== 32'h0) begin
         $display("FAIL reset_held: got %h want %h", out_imm, 32'h0);
         n_errors++;
      end
`ifdef IMMGEN_ILLEGAL_FLAG_EN
      n_checks++;
      if (illegal !== 1'b0) begin
         $display("FAIL reset_flag: got %b want 0", illegal);
         n_errors++;
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_u();
      apply(25'b10110000001110001000_10100, 3'b000, 1'b1);
      n_checks++;
      if (out_imm !== 32'b10110000001110001000_000000000000) begin
         $display("FAIL u_type: got %h want %h", out_imm, 32'b10110000001110001000_000000000000);
         n_errors++;
      end
   endtask

   task automatic test_j();
      apply(25'b1_0001101110_1_01001110_01010, 3'b001, 1'b1);
      n_checks++;
      if (out_imm !== 32'b111111111111_01001110_1_0001101110_0) begin
         $display("FAIL j_type_neg: got %h want %h", out_imm,
                  32'b111111111111_01001110_1_0001101110_0);
         n_errors++;
      end
      // Positive J immediate: upper bits must be zero.
      apply(25'b0_1000000001_0_10000001_11111, 3'b001, 1'b1);
      n_checks++;
      if (out_imm !== 32'b000000000000_10000001_0_1000000001_0) begin
         $display("FAIL j_type_pos: got %h want %h", out_imm,
                  32'b000000000000_10000001_0_1000000001_0);
         n_errors++;
      end
   endtask

   task automatic test_s_b();
      // {20 ones, 1010010, 00101}
      apply(25'b1010010_01001_10100_010_00101, 3'b010, 1'b1);
      n_checks++;
      if (out_imm !== 32'hFFFFFA45) begin
         $display("FAIL s_type_neg: got %h want %h", out_imm, 32'hFFFFFA45);
         n_errors++;
      end
      apply(25'b0111111_00000_00000_000_11111, 3'b010, 1'b1);
      n_checks++;
      if (out_imm !== 32'h000007FF) begin
         $display("FAIL s_type_pos: got %h want %h", out_imm, 32'h000007FF);
         n_errors++;
      end
      apply(25'b1_010000_11011_10101_110_0101_0, 3'b011, 1'b1);
      n_checks++;
      if (out_imm !== 32'hFFFFF20A) begin
         $display("FAIL b_type_neg: got %h want %h", out_imm, 32'hFFFFF20A);
         n_errors++;
      end
      // instr[7]=1 lands at bit 11; sign clear.
      apply(25'b0_000001_00000_00000_000_0000_1, 3'b011, 1'b1);
      n_checks++;
      if (out_imm !== 32'h00000820) begin
         $display("FAIL b_type_bit11: got %h want %h", out_imm, 32'h00000820);
         n_errors++;
      end
   endtask

   task automatic test_i();
      apply(25'b101001001001_10100_010_00101, 3'b100, 1'b1);
      n_checks++;
      if (out_imm !== 32'hFFFFFA49) begin
         $display("FAIL i_signed: got %h want %h", out_imm, 32'hFFFFFA49);
         n_errors++;
      end
      apply(25'b101001001001_10100_010_00101, 3'b110, 1'b1);
      n_checks++;
      if (out_imm !== 32'h00000A49) begin
         $display("FAIL i_unsigned: got %h want %h", out_imm, 32'h00000A49);
         n_errors++;
      end
      apply(25'b1010010_01001_10100_010_00101, 3'b101, 1'b1);
      n_checks++;
      if (out_imm !== 32'h00000009) begin
         $display("FAIL i_shift: got %h want %h", out_imm, 32'h00000009);
         n_errors++;
      end
      // instr[11:7] must not leak into an I immediate.
      apply(25'b011111111111_00000_000_11111, 3'b100, 1'b1);
      n_checks++;
      if (out_imm !== 32'h000007FF) begin
         $display("FAIL i_signed_pos: got %h want %h", out_imm, 32'h000007FF);
         n_errors++;
      end
   endtask

   task automatic test_reserved();
      apply(25'h1FFFFFF, 3'b111, 1'b1);
      n_checks++;
      if (out_imm !== 32'h0) begin
         $display("FAIL reserved: got %h want %h", out_imm, 32'h0);
         n_errors++;
      end
`ifdef IMMGEN_ILLEGAL_FLAG_EN
      n_checks++;
      if (illegal !== 1'b1) begin
         $display("FAIL flag_set: got %b want 1", illegal);
         n_errors++;
      end
      apply(25'h1FFFFFF, 3'b100, 1'b1);
      n_checks++;
      if (illegal !== 1'b0) begin
         $display("FAIL flag_clear: got %b want 0", illegal);
         n_errors++;
      end
`endif
   endtask

   task automatic test_stall();
      apply(25'b101001001001_10100_010_00101, 3'b100, 1'b1);
      for (int i = 0; i < 3; i++) begin
         apply(25'b0_1000000001_0_10000001_11111 ^ 25'(i), 3'(i), 1'b0);
         n_checks++;
         if (out_imm !== 32'hFFFFFA49) begin
            $display("FAIL stall_hold[%0d]: got %h want %h", i, out_imm, 32'hFFFFFA49);
            n_errors++;
         end
      end
   endtask

   task automatic test_back_to_back();
      apply(25'b10110000001110001000_10100, 3'b000, 1'b1);
      n_checks++;
      if (out_imm !== 32'hB0388000) begin
         $display("FAIL b2b_u: got %h want %h", out_imm, 32'hB0388000);
         n_errors++;
      end
      apply(25'b1010010_01001_10100_010_00101, 3'b101, 1'b1);
      n_checks++;
      if (out_imm !== 32'h00000009) begin
         $display("FAIL b2b_shift: got %h want %h", out_imm, 32'h00000009);
         n_errors++;
      end
   endtask

   task automatic test_async_reset();
      apply(25'b101001001001_10100_010_00101, 3'b100, 1'b1);
      // Assert reset between edges and check without any clock edge.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_imm !== 32'h0) begin
         $display("FAIL async_reset: got %h want %h", out_imm, 32'h0);
         n_errors++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      apply(25'b101001001001_10100_010_00101, 3'b110, 1'b1);
      n_checks++;
      if (out_imm !== 32'h00000A49) begin
         $display("FAIL after_reset_load: got %h want %h", out_imm, 32'h00000A49);
         n_errors++;
      end
   endtask

   initial begin
      test_reset();
      test_u();
      test_j();
      test_s_b();
      test_i();
      test_reserved();
      test_stall();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
